accum_alu_seq: RTL and testbench

//  Parametrised successor to the 8-bit accumulator ALU: WIDTH-bit accumulator datapath with valid/ready

---
 rtl/accum_alu_seq_if.sv | 36 +++
 rtl/accum_alu_seq.sv | 212 +++++++++++++++++++++
 tb/tb_accum_alu_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/accum_alu_seq_if.sv
// ----------------------------------------------------------------------------
// accum_alu_seq_if
// Command/result bundle between the operand source, the accumulator ALU and
// the result consumer.
//   Command (source -> ALU): in_valid, opcode[2:0], load, int1, int2
//   Flow control (ALU -> source): in_ready, busy
//   Result (ALU -> consumer): out, out_valid, status, zero
// Modports:
//   master : the source/consumer side (drives commands, observes results)
//   slave  : the ALU side
// ----------------------------------------------------------------------------
interface accum_alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic             load;
    logic [WIDTH-1:0] int1;
    logic [WIDTH-1:0] int2;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             status;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, opcode, load, int1, int2,
        input  in_ready, out, out_valid, status, zero, busy
    );

    modport slave (
        input  in_valid, opcode, load, int1, int2,
        output in_ready, out, out_valid, status, zero, busy
    );
endinterface

// File: rtl/accum_alu_seq.sv
// ----------------------------------------------------------------------------
// accum_alu_seq
// WIDTH-bit accumulator ALU with a valid/ready command port. ADD/SUB/logic
// ops complete one cycle after accept; SHL/SHR by k>0 walk one bit per cycle
// and complete k cycles after accept. Operand A is int1 when load is set (or
// for the first command after reset), otherwise the current accumulator.
//
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-low reset
//   bus  : accum_alu_seq_if.slave
//            in_valid/in_ready  command handshake (in_ready high only in IDLE)
//            opcode/load/int1/int2 command fields
//            out/status/zero    registered accumulator and completion flags
//            out_valid          one-cycle completion pulse
//            busy               multi-cycle shift in progress
//
// Build option: define ALU_SATURATE_EN to clamp ADD on carry to all-ones and
// SUB on borrow to zero (status still reports carry/borrow). Undefined, ADD
// and SUB wrap modulo 2^WIDTH.
// ----------------------------------------------------------------------------
module accum_alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    accum_alu_seq_if.slave bus
);

    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned XW  = WIDTH + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             status_q, status_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;
    logic             first_done_q, first_done_d;

    logic [WIDTH-1:0] b_inv;
    logic [XW-1:0]    sum_w;
    logic [XW-1:0]    diff_w;
    logic [WIDTH-1:0] exec_res;
    logic             exec_st;
    logic [WIDTH-1:0] sh_step;
    logic             sh_bit;
    logic [SHW-1:0]   amt;
    logic             is_shift;

    // Single-cycle ALU result for the EXEC state (operands already latched)
    always_comb begin
        b_inv    = ~b_q;
        sum_w    = XW'(a_q) + XW'(b_q);
        diff_w   = XW'(a_q) + XW'(b_inv) + XW'(1);
        exec_res = '0;
        exec_st  = 1'b0;
        case (op_q)
            OP_ADD: begin
                exec_st = sum_w[WIDTH];
`ifdef ALU_SATURATE_EN
                exec_res = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
`else
                exec_res = sum_w[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                // Borrow is the inverted carry of A + ~B + 1
                exec_st = ~diff_w[WIDTH];
`ifdef ALU_SATURATE_EN
                exec_res = diff_w[WIDTH] ? diff_w[WIDTH-1:0] : '0;
`else
                exec_res = diff_w[WIDTH-1:0];
`endif
            end
            // Only zero-amount shifts reach EXEC: pass A through, nothing shifted out
            OP_SHL:  exec_res = a_q;
            OP_SHR:  exec_res = a_q;
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_XOR:  exec_res = a_q ^ b_q;
            OP_NOT:  exec_res = ~a_q;
        endcase
    end

    // One-bit shift step, zero-filled, plus the bit falling off the end
    always_comb begin
        if (op_q == OP_SHL) begin
            sh_step = {a_q[WIDTH-2:0], 1'b0};
            sh_bit  = a_q[WIDTH-1];
        end else begin
            sh_step = {1'b0, a_q[WIDTH-1:1]};
            sh_bit  = a_q[0];
        end
    end

    // Command decode at the port
    always_comb begin
        amt      = bus.int2[SHW-1:0];
        is_shift = (bus.opcode == OP_SHL) || (bus.opcode == OP_SHR);
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        status_d     = status_q;
        zero_d       = zero_q;
        out_valid_d  = 1'b0;
        first_done_d = first_done_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d          = (bus.load || !first_done_q) ? bus.int1 : out_q;
                    b_d          = bus.int2;
                    op_d         = bus.opcode;
                    cnt_d        = amt;
                    first_done_d = 1'b1;
                    state_d      = (is_shift && (amt != '0)) ? ST_SHIFT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                out_d       = exec_res;
                status_d    = exec_st;
                zero_d      = (exec_res == '0);
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_SHIFT: begin
                a_d   = sh_step;
                cnt_d = cnt_q - SHW'(1);
                // Last step: publish the result and the final bit shifted out
                if (cnt_q == SHW'(1)) begin
                    out_d       = sh_step;
                    status_d    = sh_bit;
                    zero_d      = (sh_step == '0);
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered copies of the upcoming state
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d == ST_SHIFT);
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            cnt_q        <= '0;
            out_q        <= '0;
            status_q     <= 1'b0;
            zero_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
            first_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            status_q     <= status_d;
            zero_q       <= zero_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
            first_done_q <= first_done_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.status    = status_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_accum_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_accum_alu_seq
// Scoreboard bench for accum_alu_seq (WIDTH=8). The driver pushes the
// hand-computed result and completion cycle of each command; a negedge
// monitor pops and compares on every out_valid pulse.
// ----------------------------------------------------------------------------
module tb_accum_alu_seq;

    localparam int unsigned W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef struct {
        string        name;
        logic [W-1:0] out;
        logic         st;
        logic         z;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    accum_alu_seq_if #(.WIDTH(W)) bus ();

    accum_alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got pulse with out=%0d expected none (cycle %0d)",
                         bus.out, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, ".out"},    32'(bus.out),    32'(e.out));
                chk({e.name, ".status"}, 32'(bus.status), 32'(e.st));
                chk({e.name, ".zero"},   32'(bus.zero),   32'(e.z));
                chk({e.name, ".cycle"},  32'(cyc),        32'(e.cyc));
            end
        end
    end

    // Called at a negedge; holds the command until in_ready, returns at the
    // negedge after the accepting edge. acc is the accepting edge number.
    task automatic send(input string nm, input logic [2:0] op, input logic ld,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic push, input logic [W-1:0] eo, input logic es,
                        input logic ez, input int lat, output int acc);
        int n;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.load     = ld;
        bus.int1     = a;
        bus.int2     = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s.accept_timeout: got no in_ready expected in_ready within 100 cycles", nm);
        end else if (push) begin
            exp_t e;
            e.name = nm; e.out = eo; e.st = es; e.z = ez; e.cyc = acc + lat;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".out"},       32'(bus.out),       32'd0);
        chk({nm, ".status"},    32'(bus.status),    32'd0);
        chk({nm, ".zero"},      32'(bus.zero),      32'd0);
        chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({nm, ".busy"},      32'(bus.busy),      32'd0);
        chk({nm, ".in_ready"},  32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, acc2;
        logic [W-1:0] held;
        bus.in_valid = 1'b0;
        bus.opcode   = '0;
        bus.load     = 1'b0;
        bus.int1     = '0;
        bus.int2     = '0;
        @(negedge clk);
        do_reset();
        chk_idle("reset");

        // 1: accumulate +1 starting from int1
        send("t1_add0", OP_ADD, 1'b0, 8'd10, 8'd1, 1'b1, 8'd11, 1'b0, 1'b0, 1, acc);
        send("t1_add1", OP_ADD, 1'b0, 8'd10, 8'd1, 1'b1, 8'd12, 1'b0, 1'b0, 1, acc);
        send("t1_add2", OP_ADD, 1'b0, 8'd10, 8'd1, 1'b1, 8'd13, 1'b0, 1'b0, 1, acc);
        send("t1_add3", OP_ADD, 1'b0, 8'd10, 8'd1, 1'b1, 8'd14, 1'b0, 1'b0, 1, acc);
        drain("t1");
        // out holds between commands
        held = bus.out;
        repeat (3) @(negedge clk);
        chk("t1_hold.out", 32'(bus.out), 32'd14);
        chk("t1_hold.out_valid", 32'(bus.out_valid), 32'd0);

        // 2: carry out of the top bit
        do_reset();
        send("t2_add0", OP_ADD, 1'b0, 8'd220, 8'd10, 1'b1, 8'd230, 1'b0, 1'b0, 1, acc);
        send("t2_add1", OP_ADD, 1'b0, 8'd220, 8'd10, 1'b1, 8'd240, 1'b0, 1'b0, 1, acc);
        send("t2_add2", OP_ADD, 1'b0, 8'd220, 8'd10, 1'b1, 8'd250, 1'b0, 1'b0, 1, acc);
`ifdef ALU_SATURATE_EN
        send("t2_add3", OP_ADD, 1'b0, 8'd220, 8'd10, 1'b1, 8'd255, 1'b1, 1'b0, 1, acc);
`else
        send("t2_add3", OP_ADD, 1'b0, 8'd220, 8'd10, 1'b1, 8'd4,   1'b1, 1'b0, 1, acc);
`endif
        drain("t2");

        // 3: subtract down through zero into borrow
        do_reset();
        send("t3_sub0", OP_SUB, 1'b0, 8'd20, 8'd5, 1'b1, 8'd15, 1'b0, 1'b0, 1, acc);
        send("t3_sub1", OP_SUB, 1'b0, 8'd20, 8'd5, 1'b1, 8'd10, 1'b0, 1'b0, 1, acc);
        send("t3_sub2", OP_SUB, 1'b0, 8'd20, 8'd5, 1'b1, 8'd5,  1'b0, 1'b0, 1, acc);
        send("t3_sub3", OP_SUB, 1'b0, 8'd20, 8'd5, 1'b1, 8'd0,  1'b0, 1'b1, 1, acc);
`ifdef ALU_SATURATE_EN
        send("t3_sub4", OP_SUB, 1'b0, 8'd20, 8'd5, 1'b1, 8'd0,   1'b1, 1'b1, 1, acc);
`else
        send("t3_sub4", OP_SUB, 1'b0, 8'd20, 8'd5, 1'b1, 8'd251, 1'b1, 1'b0, 1, acc);
`endif
        drain("t3");

        // 4: three-step SHL, then a one-step SHR that drops a 1
        do_reset();
        send("t4_shl", OP_SHL, 1'b0, 8'd10, 8'd3, 1'b1, 8'd80, 1'b0, 1'b0, 3, acc);
        for (int i = 0; i < 2; i++) begin
            chk("t4_shift.busy",     32'(bus.busy),     32'd1);
            chk("t4_shift.in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        chk("t4_shift_last.busy", 32'(bus.busy), 32'd1);
        send("t4_shr", OP_SHR, 1'b1, 8'h81, 8'd1, 1'b1, 8'h40, 1'b1, 1'b0, 1, acc2);
        chk("t4_shr.accept_cycle", 32'(acc2), 32'(acc + 4));
        drain("t4");

        // 5: reset in the middle of a 7-step shift discards everything
        do_reset();
        send("t5_shl", OP_SHL, 1'b0, 8'd1, 8'd7, 1'b0, 8'd0, 1'b0, 1'b0, 7, acc);
        while (cyc < acc + 3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_idle("t5_after_rst");
        send("t5_add", OP_ADD, 1'b0, 8'd5, 8'd0, 1'b1, 8'd5, 1'b0, 1'b0, 1, acc);
        drain("t5");

        // 6: command held through a 5-step shift, then logic ops and a zero shift
        do_reset();
        send("t6_shl5", OP_SHL, 1'b1, 8'd3, 8'd5, 1'b1, 8'd96, 1'b0, 1'b0, 5, acc);
        send("t6_add", OP_ADD, 1'b0, 8'd0, 8'd1, 1'b1, 8'd97, 1'b0, 1'b0, 1, acc2);
        chk("t6_add.accept_cycle", 32'(acc2), 32'(acc + 6));
        send("t6_and", OP_AND, 1'b1, 8'd20, 8'd15, 1'b1, 8'd4,   1'b0, 1'b0, 1, acc);
        send("t6_or",  OP_OR,  1'b1, 8'd20, 8'd15, 1'b1, 8'd31,  1'b0, 1'b0, 1, acc);
        send("t6_xor", OP_XOR, 1'b1, 8'd20, 8'd15, 1'b1, 8'd27,  1'b0, 1'b0, 1, acc);
        send("t6_not", OP_NOT, 1'b1, 8'd20, 8'd15, 1'b1, 8'd235, 1'b0, 1'b0, 1, acc);
        send("t6_shl0", OP_SHL, 1'b1, 8'h5A, 8'd8, 1'b1, 8'h5A, 1'b0, 1'b0, 1, acc);
        send("t6_shr7", OP_SHR, 1'b1, 8'h80, 8'd7, 1'b1, 8'h01, 1'b0, 1'b0, 7, acc);
        drain("t6");
        repeat (3) @(negedge clk);
        chk("end.out_valid", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
